// File: rtl/pse_sched.sv
// pse_sched: round-robin scheduler sharing one polygon sorting engine between two requesters
module pse_sched #(
  parameter int CW       = 10,
  parameter int MAX_PTS  = 6,
  parameter int WAIT_MAX = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [2:0]    req0_num,
  input  logic [CW-1:0] req0_x,
  input  logic [CW-1:0] req0_y,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [2:0]    req1_num,
  input  logic [CW-1:0] req1_x,
  input  logic [CW-1:0] req1_y,
  output logic          req1_ready,
  output logic          eng_rst,
  output logic [2:0]    eng_point_num,
  output logic [CW-1:0] eng_xin,
  output logic [CW-1:0] eng_yin,
  input  logic          eng_valid,
  input  logic [CW-1:0] eng_xout,
  input  logic [CW-1:0] eng_yout,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [CW-1:0] rsp_x,
  output logic [CW-1:0] rsp_y,
  output logic          rsp_last,
  output logic          rsp_err
);
  localparam int WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {IDLE, COLLECT, FEED, WAIT, ERR} state_t;

  state_t          state, state_n;
  logic            gnt, rr;
  logic [2:0]      num, cnt, beats;
  logic [WW-1:0]   wdog;
  logic [CW-1:0]   bx [MAX_PTS];
  logic [CW-1:0]   by [MAX_PTS];
  logic            any_req, nxt_gnt, gv, hs, legal, cnt_last, beat_last, timeout;
  logic [CW-1:0]   gx, gy;

  assign any_req    = req0_valid || req1_valid;
  assign nxt_gnt    = rr ? req1_valid : !req0_valid;
  assign gv         = gnt ? req1_valid : req0_valid;
  assign gx         = gnt ? req1_x : req0_x;
  assign gy         = gnt ? req1_y : req0_y;
  assign hs         = (state == COLLECT) && gv;
  assign legal      = (num >= 3'd3) && (num <= 3'(MAX_PTS));
  assign cnt_last   = cnt == num - 3'd1;
  assign beat_last  = beats == num - 3'd1;
  assign timeout    = (beats == 3'd0) && !eng_valid && (wdog == WW'(WAIT_MAX - 1));
  assign req0_ready = (state == COLLECT) && !gnt;
  assign req1_ready = (state == COLLECT) && gnt;
  assign eng_xin    = (state == FEED) ? bx[cnt] : '0;
  assign eng_yin    = (state == FEED) ? by[cnt] : '0;

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;

  // next-state: collect until the set is complete, feed it, then wait for the sorted stream
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = any_req ? COLLECT : IDLE;
      COLLECT: state_n = !hs ? COLLECT : !legal ? ERR : cnt_last ? FEED : COLLECT;
      FEED:    state_n = cnt_last ? WAIT : FEED;
      WAIT:    state_n = (eng_valid && beat_last) ? IDLE : timeout ? ERR : WAIT;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // point buffer; illegal sets are consumed but never stored
  always_ff @(posedge clk)
    if (hs && legal) begin
      bx[cnt] <= gx;
      by[cnt] <= gy;
    end

  // grant, counters, engine control and response registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gnt           <= 1'b0;
      rr            <= 1'b0;
      num           <= '0;
      cnt           <= '0;
      beats         <= '0;
      wdog          <= '0;
      eng_rst       <= 1'b1;
      eng_point_num <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_x         <= '0;
      rsp_y         <= '0;
      rsp_last      <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          gnt <= nxt_gnt;
          num <= nxt_gnt ? req1_num : req0_num;
          cnt <= '0;
        end
        COLLECT: if (hs) begin
          cnt <= (legal && cnt_last) ? 3'd0 : cnt + 3'd1;
          if (legal && cnt_last) begin
            eng_point_num <= num;
            eng_rst       <= 1'b0;
          end
        end
        FEED: begin
          cnt <= cnt + 3'd1;
          if (cnt_last) begin
            beats <= '0;
            wdog  <= '0;
          end
        end
        WAIT: if (eng_valid) begin
          rsp_valid <= 1'b1;
          rsp_id    <= gnt;
          rsp_x     <= eng_xout;
          rsp_y     <= eng_yout;
          beats     <= beats + 3'd1;
          if (beat_last) begin
            rsp_last <= 1'b1;
            eng_rst  <= 1'b1;
            rr       <= ~gnt;
          end
        end else if (beats == 3'd0) begin
          wdog <= wdog + WW'(1);
          if (timeout) eng_rst <= 1'b1;
        end
        ERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_last  <= 1'b1;
          rsp_x     <= '0;
          rsp_y     <= '0;
          rsp_id    <= gnt;
          eng_rst   <= 1'b1;
          rr        <= ~gnt;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_pse_sched.sv
// tb_pse_sched: randomized scoreboard bench for pse_sched with a reversing engine model
module tb_pse_sched;
  localparam int CW = 10, MAX_PTS = 6, WAIT_MAX = 64;

  logic          clk = 1'b0, reset = 1'b1;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]    req0_num, req1_num, eng_point_num;
  logic [CW-1:0] req0_x, req0_y, req1_x, req1_y;
  logic          eng_rst, eng_valid;
  logic [CW-1:0] eng_xin, eng_yin, eng_xout, eng_yout;
  logic          rsp_valid, rsp_id, rsp_last, rsp_err;
  logic [CW-1:0] rsp_x, rsp_y;

  typedef struct {
    bit            id;
    logic [CW-1:0] x, y;
    bit            last, err;
    int            num;
  } beat_t;

  beat_t         exp_q[$];
  int            vectors = 0, errs = 0;
  bit            skip_chk = 0;
  bit            rr_m = 0;
  int            pn [2];
  logic [CW-1:0] px [2][MAX_PTS];
  logic [CW-1:0] py [2][MAX_PTS];
  logic [CW-1:0] cx [MAX_PTS];
  logic [CW-1:0] cy [MAX_PTS];

  pse_sched #(.CW(CW), .MAX_PTS(MAX_PTS), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_num(req0_num), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_num(req1_num), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
    .eng_rst(eng_rst), .eng_point_num(eng_point_num), .eng_xin(eng_xin), .eng_yin(eng_yin),
    .eng_valid(eng_valid), .eng_xout(eng_xout), .eng_yout(eng_yout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .rsp_last(rsp_last), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic set_req(input bit id, input bit v, input logic [CW-1:0] x, input logic [CW-1:0] y);
    if (id) begin
      req1_valid = v; req1_x = x; req1_y = y;
    end else begin
      req0_valid = v; req0_x = x; req0_y = y;
    end
  endtask

  task automatic rand_pts(input bit id, input int n);
    pn[id] = n;
    for (int k = 0; k < MAX_PTS; k++) begin
      px[id][k] = CW'($urandom_range(0, (1 << CW) - 1));
      py[id][k] = CW'($urandom_range(0, (1 << CW) - 1));
    end
  endtask

  function automatic int pick_num();
    int t;
    if ($urandom_range(0, 4) != 0) return $urandom_range(3, MAX_PTS);
    t = $urandom_range(0, 3);
    return (t == 3) ? 7 : t;
  endfunction

  // Expected responses: the engine model returns the set reversed; illegal or silent sets give one error beat.
  task automatic push_exp(input bit id, input bit silent);
    beat_t b;
    int    n;
    n = pn[id];
    b.id = id;
    b.num = n;
    if (n < 3 || n > MAX_PTS || silent) begin
      b.x = '0; b.y = '0; b.last = 1; b.err = 1;
      exp_q.push_back(b);
    end else
      for (int k = n - 1; k >= 0; k--) begin
        b.x = px[id][k]; b.y = py[id][k]; b.last = (k == 0); b.err = 0;
        exp_q.push_back(b);
      end
    rr_m = ~id;
  endtask

  task automatic drive(input bit id, input int gaps);
    int beats, t;
    bit ok;
    beats = (pn[id] >= 3 && pn[id] <= MAX_PTS) ? pn[id] : 1;
    if (id) req1_num = 3'(pn[1]);
    else    req0_num = 3'(pn[0]);
    for (int k = 0; k < beats; k++) begin
      if (k > 0 && (gaps == 2 || (gaps == 1 && $urandom_range(0, 2) == 0))) begin
        set_req(id, 0, '0, '0);
        repeat ((gaps == 2) ? 1 : $urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
      set_req(id, 1, px[id][k], py[id][k]);
      t = 0;
      do begin
        @(negedge clk);
        ok = id ? req1_ready : req0_ready;
        @(posedge clk); #1;
        t++;
      end while (!ok && t < 1000);
      if (!ok) begin
        vectors++; errs++;
        $display("FAIL handshake: req%0d beat %0d got no ready within %0d cycles", id, k, t);
        break;
      end
    end
    set_req(id, 0, '0, '0);
  endtask

  task automatic do_pair(input int gaps, input bit s0, input bit s1);
    bit first;
    first = rr_m;
    push_exp(first, first ? s1 : s0);
    push_exp(~first, first ? s0 : s1);
    fork
      drive(0, gaps);
      drive(1, gaps);
    join
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      vectors++; errs++;
      $display("FAIL drain: %0d expected beats still outstanding", exp_q.size());
    end
  endtask

  // monitor: pop and compare every response beat; ready may only go to the requester being served
  always @(negedge clk) begin
    beat_t e;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        vectors++; errs++;
        $display("FAIL unexpected_rsp: id=%0d x=%0d y=%0d err=%0d", rsp_id, rsp_x, rsp_y, rsp_err);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", int'(rsp_id), int'(e.id));
        chk("rsp_x", int'(rsp_x), int'(e.x));
        chk("rsp_y", int'(rsp_y), int'(e.y));
        chk("rsp_last", int'(rsp_last), int'(e.last));
        chk("rsp_err", int'(rsp_err), int'(e.err));
      end
    end
    if (!skip_chk && (req0_ready || req1_ready)) begin
      if (exp_q.size() == 0) begin
        vectors++; errs++;
        $display("FAIL ready_owner: ready=%0d%0d with no job pending", req1_ready, req0_ready);
      end else
        chk("ready_owner", int'({req1_ready, req0_ready}), exp_q[0].id ? 2 : 1);
    end
  end

  // engine model: capture the fed points, then return them reversed with random latency and gaps
  initial begin
    int n, w, g;
    bit ok, silent;
    eng_valid = 0; eng_xout = '0; eng_yout = '0;
    forever begin
      @(negedge clk);
      if (eng_rst !== 1'b0) continue;
      silent = 0;
      if (!skip_chk) begin
        if (exp_q.size() == 0 || (exp_q[0].err && (exp_q[0].num < 3 || exp_q[0].num > MAX_PTS))) begin
          vectors++; errs++;
          $display("FAIL eng_rst_drop: eng_rst=0 with no legal job in service");
        end else begin
          chk("eng_point_num", int'(eng_point_num), exp_q[0].num);
          silent = exp_q[0].err;
        end
      end
      n = int'(eng_point_num);
      if (n > MAX_PTS) n = MAX_PTS;
      ok = 1;
      for (int k = 0; k < n; k++) begin
        if (k > 0) @(negedge clk);
        if (eng_rst) begin
          ok = 0;
          break;
        end
        cx[k] = eng_xin;
        cy[k] = eng_yin;
      end
      if (!ok) continue;
      if (silent) begin
        w = 0;
        @(negedge clk);
        while (eng_rst == 1'b0 && w < WAIT_MAX + 10) begin
          w++;
          @(negedge clk);
        end
        chk("wait_cycles", w, WAIT_MAX);
      end else begin
        g = $urandom_range(1, 8);
        for (int k = n - 1; k >= 0; k--) begin
          repeat (g) begin
            @(posedge clk); #1;
            eng_valid = 0;
          end
          if (eng_rst) break;
          eng_valid = 1; eng_xout = cx[k]; eng_yout = cy[k];
          g = $urandom_range(1, 3);
        end
        @(posedge clk); #1;
        eng_valid = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    bit id, s0, s1;
    set_req(0, 0, '0, '0);
    set_req(1, 0, '0, '0);
    req0_num = '0; req1_num = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_eng_rst", int'(eng_rst), 1);
    chk("rst_eng_point_num", int'(eng_point_num), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_ready", int'({req1_ready, req0_ready}), 0);
    chk("rst_eng_xin", int'(eng_xin), 0);
    chk("rst_rsp_x", int'(rsp_x), 0);
    @(negedge clk) reset = 0;
    rr_m = 0;
    repeat (2) begin
      rand_pts(0, 3);
      rand_pts(1, 3);
      do_pair(0, 0, 0);
    end
    pn[0] = 4;
    px[0][0] = 10'd0; py[0][0] = 10'd0;
    px[0][1] = 10'd5; py[0][1] = 10'd0;
    px[0][2] = 10'd5; py[0][2] = 10'd5;
    px[0][3] = 10'd0; py[0][3] = 10'd5;
    push_exp(0, 0);
    drive(0, 0);
    rand_pts(1, 2);
    push_exp(1, 0);
    drive(1, 0);
    rand_pts(0, 5);
    push_exp(0, 1);
    drive(0, 0);
    rand_pts(1, 6);
    push_exp(1, 0);
    drive(1, 2);
    drain();
    skip_chk = 1;
    rand_pts(0, 5);
    drive(0, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("midrst_eng_rst", int'(eng_rst), 1);
    chk("midrst_eng_point_num", int'(eng_point_num), 0);
    chk("midrst_eng_xin", int'(eng_xin), 0);
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    chk("midrst_ready", int'({req1_ready, req0_ready}), 0);
    repeat (2) @(negedge clk);
    reset = 0;
    skip_chk = 0;
    rr_m = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("postrst_eng_rst", int'(eng_rst), 1);
    rand_pts(0, 3);
    push_exp(0, 0);
    drive(0, 1);
    drain();
    for (int i = 0; i < 40; i++) begin
      rand_pts(0, pick_num());
      rand_pts(1, pick_num());
      s0 = ($urandom_range(0, 7) == 0);
      s1 = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        do_pair(1, s0, s1);
      else begin
        id = 1'($urandom_range(0, 1));
        push_exp(id, id ? s1 : s0);
        drive(id, 1);
      end
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/pse_sched.md
Name: pse_sched

Overview:
- Scheduler that shares one polygon sorting engine (10-bit X/Y points, 3..6 per set, sorted around point 0) between two requesters.
- Round-robin arbitrates and collects the granted requester's full point set into a local buffer.
- Resynchronises the engine with its reset, then streams the points back-to-back; the engine's LOAD phase cannot stall.
- Returns the engine's sorted output stream tagged with requester ID; includes a watchdog on engine completion.

Parameters:
- CW, 10, coordinate width; must match engine.
- MAX_PTS, 6, buffer depth and largest legal point_num.
- WAIT_MAX, 64, cycles allowed in WAIT before the first engine output beat; exceeding this causes a timeout error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req0_valid  in  1  requester 0 point valid
- req0_num  in  3  requester 0 point count; held constant for whole set
- req0_x  in  CW  requester 0 point X
- req0_y  in  CW  requester 0 point Y
- req0_ready  out  1  point accepted when valid&ready
- req1_valid, req1_num, req1_x, req1_y, req1_ready  same as port 0
- eng_rst  out  1  drives engine reset (registered)
- eng_point_num  out  3  engine point count (registered)
- eng_xin  out  CW  engine X input
- eng_yin  out  CW  engine Y input
- eng_valid  in  1  engine output beat valid
- eng_xout  in  CW  engine sorted X
- eng_yout  in  CW  engine sorted Y
- rsp_valid  out  1  response beat; no backpressure
- rsp_id  out  1  requester owning the beat
- rsp_x  out  CW  sorted X
- rsp_y  out  CW  sorted Y
- rsp_last  out  1  final beat of the set
- rsp_err  out  1  error beat

Behaviour:
- Reset values: state IDLE, eng_rst=1, eng_point_num=0, rsp_*=0, rr pointer=0 (req0 favoured), counters=0, req*_ready=0.
- States: IDLE, COLLECT, FEED, WAIT, ERR.
- eng_rst=1 in IDLE, COLLECT and ERR; 0 in FEED and WAIT. It is a registered output.
- IDLE:
  - If any reqN_valid, pick the favoured requester when it is valid, else the other.
  - Register gnt and num=reqgnt_num; enter COLLECT.
  - req*_ready=0 in IDLE.
- COLLECT:
  - req<gnt>_ready=1 while beats collected < num; the other requester's ready is 0.
  - Each handshake stores the point in buf[cnt] and increments cnt.
  - Legal num is 3..6. On the handshake of beat num-1: eng_point_num<=num, eng_rst<=0, enter FEED.
  - Illegal num (0,1,2,7): exactly one beat is consumed and discarded, then enter ERR.
- FEED:
  - Lasts exactly num cycles. In FEED cycle k, eng_xin/eng_yin=buf[k]; the engine samples at the end of each cycle.
  - After cycle num-1, enter WAIT with beat and watchdog counters cleared.
  - eng_xin/eng_yin=0 outside FEED.
- WAIT:
  - Each cycle with eng_valid=1 registers rsp_valid=1, rsp_x/y=eng_xout/yout, rsp_id=gnt. Latency is 1 cycle from eng_valid.
  - The beat with index num-1 also sets rsp_last=1. Then eng_rst<=1, the rr pointer favours the non-granted requester, and the state returns to IDLE.
  - The watchdog increments only while zero beats have been received. On reaching WAIT_MAX, enter ERR.
  - eng_valid outside WAIT is ignored.
- ERR:
  - One cycle. Registers rsp_valid=1, rsp_err=1, rsp_last=1, rsp_x/y=0, rsp_id=gnt.
  - eng_rst=1; the rr pointer flips; return to IDLE.
- eng_point_num is held stable from FEED entry until IDLE; the engine uses it during output.
- Back-to-back jobs: the next IDLE grant can occur the cycle after last/ERR. The engine stays in reset from that point.
- A requester that drops valid mid-set simply stalls COLLECT; there is no timeout in COLLECT.
- Reset mid-operation: everything returns to reset values immediately, engine forced into reset, partially collected set discarded, no response emitted.

Test Plan:
- req0 sends 4 points (0,0),(5,0),(5,5),(0,5), req1 idle -> eng_rst drops after 4th handshake. FEED drives the points in order, eng_point_num=4. 4 rsp beats with id=0 mirror engine output; last only on beat 4; rsp_err=0.
- req0 and req1 both valid from reset, each with num=3 -> req0 served first, then req1. On a second simultaneous request, req0 is served first again, since rr favours the requester not just served. No ready to the non-granted requester at any time.
- req1_num=2 -> one beat consumed, single response with rsp_err=1, last=1, id=1, x=y=0; eng_rst never drops.
- Engine held silent, eng_valid=0 -> exactly WAIT_MAX=64 cycles in WAIT, then err/last beat, eng_rst=1, IDLE.
- num=6 set with req0_valid gaps every other cycle -> buffer correct, FEED still 6 contiguous cycles.
- reset asserted during FEED cycle 2 -> all outputs to reset values, eng_rst=1, no rsp. A fresh 3-point job afterwards completes normally.
